// File: rtl/mips_trace_buffer.sv
// Trace capture FIFO behind the single-cycle MIPS core: one {pc, ula, mem} record per
// clock in, serialized as three 32-bit valid/ready words out. Records that hit a full FIFO are dropped and counted.
module mips_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cap_en,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       ula_in,
    input  logic [31:0]       mem_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);

    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

    localparam logic [ADDR_W:0]   CNT_ONE   = 1;
    localparam logic [ADDR_W:0]   CNT_DEPTH = DEPTH;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

    state_t              r_state, w_state_nxt;
    logic [95:0]         r_mem [DEPTH];
    logic [95:0]         r_out_rec;
    logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;
    logic [15:0]         r_drop_cnt;
    logic                w_full, w_nonempty, w_push, w_drop, w_pop;

    // Full/empty come from the occupancy count; pointers are free-running mod DEPTH.
    assign w_full     = (r_count == CNT_DEPTH);
    assign w_nonempty = (r_count != '0);
    assign w_push     = cap_en & ~w_full;
    assign w_drop     = cap_en & w_full;

    assign count    = r_count;
    assign full     = w_full;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clock) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        case (r_state)
            IDLE: begin
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = W0;
                end
            end
            W0: begin
                out_valid = 1'b1;
                out_data  = r_out_rec[95:64];
                if (out_ready) w_state_nxt = W1;
            end
            W1: begin
                out_valid = 1'b1;
                out_data  = r_out_rec[63:32];
                if (out_ready) w_state_nxt = W2;
            end
            W2: begin
                out_valid = 1'b1;
                out_data  = r_out_rec[31:0];
                // Reload straight into W0 so back-to-back entries have no idle bubble.
                if (out_ready) begin
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = W0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset && w_push) r_mem[r_wr_ptr] <= {pc_in, ula_in, mem_in};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_rec  <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop) begin
                r_out_rec <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: directed scenarios plus a random run, all checked
// against a queue-based model of the trace FIFO and its word serializer.
module tb_mips_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              cap_en = 1'b0;
    logic [31:0]       pc_in = '0, ula_in = '0, mem_in = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [31:0]       out_data;
    logic [ADDR_W:0]   count;
    logic              full, overflow;
    logic [15:0]       drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    mips_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .cap_en(cap_en),
        .pc_in(pc_in), .ula_in(ula_in), .mem_in(mem_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    // Model: queue of stored records, plus the record being emitted and its word index.
    logic [95:0] mq[$];
    bit          m_busy = 0;
    logic [95:0] m_rec  = '0;
    int          m_idx  = 0;
    bit          m_ovf  = 0;
    int          m_drop = 0;

    function automatic void model_step(bit rst, bit cap, logic [95:0] rec, bit rdy);
        bit was_full;
        was_full = (mq.size() == DEPTH);
        if (!rst) begin
            mq.delete();
            m_busy = 0; m_idx = 0; m_ovf = 0; m_drop = 0;
            return;
        end
        if (!m_busy) begin
            if (mq.size() > 0) begin m_rec = mq.pop_front(); m_busy = 1; m_idx = 0; end
        end else if (rdy) begin
            if (m_idx < 2) m_idx++;
            else if (mq.size() > 0) begin m_rec = mq.pop_front(); m_idx = 0; end
            else m_busy = 0;
        end
        if (cap) begin
            if (was_full) begin m_ovf = 1; if (m_drop < 65535) m_drop++; end
            else mq.push_back(rec);
        end
    endfunction

    function automatic logic [31:0] m_word();
        logic [95:0] sh;
        sh = m_rec >> (32 * (2 - m_idx));
        return m_busy ? sh[31:0] : 32'h0;
    endfunction

    task automatic cyc(input bit rst, input bit cap, input logic [31:0] pc,
                       input logic [31:0] ula, input logic [31:0] mem, input bit rdy);
        reset = rst; cap_en = cap; pc_in = pc; ula_in = ula; mem_in = mem; out_ready = rdy;
        @(posedge clock);
        model_step(rst, cap, {pc, ula, mem}, rdy);
        #1;
    endtask

    task automatic test_reset();
        cyc(0, 1, 32'h11, 32'h22, 32'h33, 1);
        cyc(0, 1, 32'h11, 32'h22, 32'h33, 1);
        n_checks++; if (count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", out_data); else n_pass++;
        n_checks++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop got=%0d exp=0", drop_cnt); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
    endtask

    task automatic test_single();
        logic [31:0] exp_w [3] = '{32'h4, 32'h10, 32'hAB};
        cyc(1, 1, 32'h4, 32'h10, 32'hAB, 1);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_lat got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (count !== 5'd1) $display("FAIL single_cnt got=%0d exp=1", count); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 0, 0, 1);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_w[k])
                $display("FAIL single_word%0d got=%b/%h exp=1/%h", k, out_valid, out_data, exp_w[k]);
            else n_pass++;
        end
        cyc(1, 0, 0, 0, 0, 1);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_idle got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_stall();
        cyc(1, 1, 32'h100, 32'h200, 32'h300, 0);
        cyc(1, 0, 0, 0, 0, 0);
        n_checks++; if (out_data !== 32'h100) $display("FAIL stall_w0 got=%h exp=100", out_data); else n_pass++;
        cyc(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h200)
                $display("FAIL stall_hold%0d got=%b/%h exp=1/200", i, out_valid, out_data);
            else n_pass++;
            cyc(1, 0, 0, 0, 0, 0);
        end
        n_checks++; if (out_data !== 32'h200) $display("FAIL stall_w1 got=%h exp=200", out_data); else n_pass++;
        cyc(1, 0, 0, 0, 0, 1);
        n_checks++; if (out_data !== 32'h300) $display("FAIL stall_w2 got=%h exp=300", out_data); else n_pass++;
        cyc(1, 0, 0, 0, 0, 1);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stall_idle got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) cyc(1, 1, i, i + 32'h1000, i + 32'h2000, 0);
        n_checks++; if (count !== 5'd16) $display("FAIL ovf_count got=%0d exp=16", count); else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", full); else n_pass++;
        n_checks++; if (drop_cnt !== 16'd3) $display("FAIL ovf_drop got=%0d exp=3", drop_cnt); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else n_pass++;
        n_checks++; if (out_data !== 32'h0) $display("FAIL ovf_head got=%h exp=0", out_data); else n_pass++;
    endtask

    // Continues from the full FIFO left by test_overflow.
    task automatic test_full_w2_drop();
        cyc(1, 0, 0, 0, 0, 1);
        n_checks++; if (out_data !== 32'h1000) $display("FAIL w2d_w1 got=%h exp=1000", out_data); else n_pass++;
        cyc(1, 0, 0, 0, 0, 1);
        n_checks++; if (out_data !== 32'h2000) $display("FAIL w2d_w2 got=%h exp=2000", out_data); else n_pass++;
        cyc(1, 1, 32'hDEAD, 32'hBEEF, 32'hCAFE, 1);
        n_checks++; if (count !== 5'd15) $display("FAIL w2d_count got=%0d exp=15", count); else n_pass++;
        n_checks++; if (drop_cnt !== 16'd4) $display("FAIL w2d_drop got=%0d exp=4", drop_cnt); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h1)
            $display("FAIL w2d_nobubble got=%b/%h exp=1/1", out_valid, out_data);
        else n_pass++;
        for (int i = 1; i <= 16; i++) begin
            for (int k = 0; k < 3; k++) begin
                logic [31:0] e;
                e = i + k * 32'h1000;
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== e)
                    $display("FAIL drain_e%0d_w%0d got=%b/%h exp=1/%h", i, k, out_valid, out_data, e);
                else n_pass++;
                cyc(1, 0, 0, 0, 0, 1);
            end
        end
        n_checks++;
        if (out_valid !== 1'b0 || count !== 5'd0)
            $display("FAIL drain_end got=%b/%0d exp=0/0", out_valid, count);
        else n_pass++;
    endtask

    task automatic test_reset_midentry();
        for (int i = 0; i < 6; i++) cyc(1, 1, 32'h50 + i, 32'h60 + i, 32'h70 + i, 0);
        cyc(1, 0, 0, 0, 0, 1);
        n_checks++;
        if (count !== 5'd5 || out_data !== 32'h60)
            $display("FAIL mid_pre got=%0d/%h exp=5/60", count, out_data);
        else n_pass++;
        cyc(0, 0, 0, 0, 0, 0);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL mid_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL mid_ovf got=%b exp=0", overflow); else n_pass++;
        cyc(1, 1, 32'h77, 32'h88, 32'h99, 1);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] e;
            e = 32'h77 + k * 32'h11;
            cyc(1, 0, 0, 0, 0, 1);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e)
                $display("FAIL mid_after_w%0d got=%b/%h exp=1/%h", k, out_valid, out_data, e);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bit rst, cap, rdy;
            rst = ($urandom_range(0, 249) != 0);
            cap = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 5);
            cyc(rst, cap, $urandom, $urandom, $urandom, rdy);
            n_checks++;
            if (out_valid !== m_busy || (m_busy && out_data !== m_word()))
                $display("FAIL rand_out c=%0d got=%b/%h exp=%b/%h", c, out_valid, out_data, m_busy, m_word());
            else n_pass++;
            n_checks++;
            if (count !== 5'(mq.size()) || full !== (mq.size() == DEPTH))
                $display("FAIL rand_cnt c=%0d got=%0d/%b exp=%0d", c, count, full, mq.size());
            else n_pass++;
            n_checks++;
            if (overflow !== m_ovf || drop_cnt !== 16'(m_drop))
                $display("FAIL rand_drop c=%0d got=%b/%0d exp=%b/%0d", c, overflow, drop_cnt, m_ovf, m_drop);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_full_w2_drop();
        test_reset_midentry();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
